// File: rtl/conv3x3_stream_if.sv
// Pixel stream bundle: input pixel handshake plus the filtered output strobe.
// Latency: none (wires only).
// Backpressure: data_in_ready gates the input side; the output side has no ready.
interface conv3x3_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_in_valid;
    logic             data_in_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_out_valid;
    logic             frame_done;

    // master = pixel source / result sink, slave = the filter
    modport master (
        output data_in, data_in_valid,
        input  data_in_ready, data_out, data_out_valid, frame_done
    );
    modport slave (
        input  data_in, data_in_valid,
        output data_in_ready, data_out, data_out_valid, frame_done
    );
endinterface

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution (bypass / sharpen / programmable) with border pass-through.
// Latency: output pixel (r,c) appears 3 cycles after the advance that completes its window.
// Backpressure: input ready drops for COLS+1 flush cycles at end of frame; output never stalls.
// Ports: clk, reset (sync, active-low), mode_i, coef_wr_i/coef_addr_i/coef_data_i (bank write),
//        strm (slave): data_in/_valid/_ready in, data_out/_valid + frame_done out.
module conv3x3_stream #(
    parameter int WIDTH = 8,
    parameter int COLS  = 6,
    parameter int ROWS  = 5,
    parameter int CW    = 6,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode_i,
    input  logic                 coef_wr_i,
    input  logic [3:0]           coef_addr_i,
    input  logic signed [CW-1:0] coef_data_i,
    conv3x3_stream_if.slave      strm
);
    localparam int NPIX  = ROWS * COLS;
    localparam int PW    = WIDTH + CW + 1;   // one product
    localparam int SW    = WIDTH + CW + 4;   // sum of nine products
    localparam int DEPTH = 2 * COLS + 2;     // oldest tap is 2*COLS+2 pixels back
    localparam int SCW   = $clog2(NPIX + COLS + 2);
    localparam int CCW   = $clog2(COLS + 1);
    localparam int RCW   = $clog2(ROWS + 1);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic logic signed [CW-1:0] sharp_tap(input int t);
        case (t)
            4:          sharp_tap = CW'(5);
            1, 3, 5, 7: sharp_tap = '1;
            default:    sharp_tap = '0;
        endcase
    endfunction

    state_t               state_q;
    logic                 ready_q;
    logic [SCW-1:0]       pix_cnt_q;
    logic [CCW-1:0]       flush_cnt_q;
    logic [SCW-1:0]       step_q;      // index of the next pipeline advance in this frame
    logic [CCW-1:0]       oc_q;        // position of the next output pixel
    logic [RCW-1:0]       or_q;
    logic [1:0]           mode_act_q;
    logic signed [CW-1:0] bank_q     [9];
    logic signed [CW-1:0] coef_act_q [9];

    logic                 accept, advance, emit;
    logic [WIDTH-1:0]     line_q [DEPTH];  // line_q[0] is the previous pixel
    logic [WIDTH-1:0]     win    [9];
    logic signed [CW-1:0] coef_sel [9];

    logic signed [PW-1:0] prod_q [9];
    logic                 s1_vld_q, s1_pass_q, s1_last_q;
    logic [WIDTH-1:0]     s1_ctr_q;
    logic signed [SW-1:0] sum_d, sum_q, res;
    logic                 s2_vld_q, s2_pass_q, s2_last_q;
    logic [WIDTH-1:0]     s2_ctr_q;
    logic [WIDTH-1:0]     sat_d, dout_q;
    logic                 dout_vld_q, done_q;

    assign accept  = ready_q & strm.data_in_valid;
    assign advance = accept | (state_q == FLUSH);
    // The first accept of a frame is step 0, so a stale step_q in IDLE must not emit.
    assign emit    = advance && (state_q != IDLE) && (step_q >= SCW'(COLS + 1));

    // Tap t (raster in the window) lies (2-t/3)*COLS + (2-t%3) pixels behind the
    // newest pixel; the newest one is taken straight from the input bus.
    for (genvar t = 0; t < 8; t++) begin : g_tap
        assign win[t] = line_q[(2 - t / 3) * COLS + (2 - t % 3) - 1];
    end
    assign win[8] = strm.data_in;

    always_comb begin
        for (int t = 0; t < 9; t++) begin
            coef_sel[t] = (mode_act_q == 2'd2) ? coef_act_q[t] : sharp_tap(t);
        end
    end

    // Control FSM, counters, coefficient bank and frame shadow registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            pix_cnt_q   <= '0;
            flush_cnt_q <= '0;
            step_q      <= '0;
            oc_q        <= '0;
            or_q        <= '0;
            mode_act_q  <= 2'd0;
            for (int t = 0; t < 9; t++) begin
                bank_q[t]     <= sharp_tap(t);
                coef_act_q[t] <= sharp_tap(t);
            end
        end else begin
            if (coef_wr_i && coef_addr_i <= 4'd8) begin
                bank_q[coef_addr_i] <= coef_data_i;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= RUN;
                        pix_cnt_q  <= SCW'(1);
                        step_q     <= SCW'(1);
                        oc_q       <= '0;
                        or_q       <= '0;
                        mode_act_q <= mode_i;
                        coef_act_q <= bank_q;
                    end
                end
                RUN: begin
                    if (accept) begin
                        step_q <= step_q + SCW'(1);
                        if (pix_cnt_q == SCW'(NPIX - 1)) begin
                            state_q     <= FLUSH;
                            ready_q     <= 1'b0;
                            flush_cnt_q <= '0;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + SCW'(1);
                        end
                    end
                end
                FLUSH: begin
                    step_q <= step_q + SCW'(1);
                    if (flush_cnt_q == CCW'(COLS)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + CCW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            if (emit) begin
                if (oc_q == CCW'(COLS - 1)) begin
                    oc_q <= '0;
                    or_q <= or_q + RCW'(1);
                end else begin
                    oc_q <= oc_q + CCW'(1);
                end
            end
        end
    end

    // Line buffer: one shift per advance; flush cycles shift in don't-care data,
    // which only ever lands in border windows.
    always_ff @(posedge clk) begin
        if (advance) begin
            line_q[0] <= strm.data_in;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int t = 0; t < 9; t++) begin
            sum_d = sum_d + SW'(prod_q[t]);
        end
    end

    assign res = sum_q >>> SHIFT;

    always_comb begin
        if (res < 0)
            sat_d = '0;
        else if (res > MAXV)
            sat_d = '1;
        else
            sat_d = res[WIDTH-1:0];
    end

    // MAC datapath registers; they only load when their stage holds a live pixel.
    always_ff @(posedge clk) begin
        if (emit) begin
            for (int t = 0; t < 9; t++) begin
                prod_q[t] <= PW'($signed({1'b0, win[t]})) * PW'(coef_sel[t]);
            end
            s1_ctr_q  <= win[4];
            // Border and bypass decisions are frozen here, so a new frame's
            // mode cannot leak into the tail of the previous one.
            s1_pass_q <= (or_q == '0) || (or_q == RCW'(ROWS - 1)) ||
                         (oc_q == '0) || (oc_q == CCW'(COLS - 1)) ||
                         (mode_act_q == 2'd0) || (mode_act_q == 2'd3);
            s1_last_q <= (or_q == RCW'(ROWS - 1)) && (oc_q == CCW'(COLS - 1));
        end
        if (s1_vld_q) begin
            sum_q     <= sum_d;
            s2_ctr_q  <= s1_ctr_q;
            s2_pass_q <= s1_pass_q;
            s2_last_q <= s1_last_q;
        end
    end

    // Stage valids and the output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            s1_vld_q   <= emit;
            s2_vld_q   <= s1_vld_q;
            dout_vld_q <= s2_vld_q;
            done_q     <= s2_vld_q & s2_last_q;
            if (s2_vld_q) begin
                dout_q <= s2_pass_q ? s2_ctr_q : sat_d;
            end
        end
    end

    assign strm.data_in_ready  = ready_q;
    assign strm.data_out       = dout_q;
    assign strm.data_out_valid = dout_vld_q;
    assign strm.frame_done     = done_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
module tb_conv3x3_stream;
    localparam int WIDTH = 8;
    localparam int COLS  = 6;
    localparam int ROWS  = 5;
    localparam int CW    = 6;
    localparam int NPIX  = ROWS * COLS;

    typedef struct { int val; bit done; int t; } out_t;
    typedef struct { int addr; int data; } wr_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [1:0]           mode = 2'd1;
    logic                 coef_wr = 1'b0;
    logic [3:0]           coef_addr = 4'd0;
    logic signed [CW-1:0] coef_data = '0;

    conv3x3_stream_if #(.WIDTH(WIDTH)) s0 ();
    conv3x3_stream_if #(.WIDTH(WIDTH)) s3 ();
    assign s3.data_in       = s0.data_in;
    assign s3.data_in_valid = s0.data_in_valid;

    conv3x3_stream #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .CW(CW), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .mode_i(mode), .coef_wr_i(coef_wr),
        .coef_addr_i(coef_addr), .coef_data_i(coef_data), .strm(s0));
    conv3x3_stream #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .CW(CW), .SHIFT(3)) dut3 (
        .clk(clk), .reset(reset), .mode_i(mode), .coef_wr_i(coef_wr),
        .coef_addr_i(coef_addr), .coef_data_i(coef_data), .strm(s3));

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   edge_cnt = 0;
    out_t obs0[$], obs1[$], exp0[$], exp1[$];
    wr_t  wr_q[$];
    int   frm [ROWS][COLS];
    int   sharp [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    int   bank_m [9];
    int   snap_bank [9];
    int   snap_mode;
    int   last0 [NPIX];
    int   last1 [NPIX];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (s0.data_out_valid === 1'b1) obs0.push_back('{int'(s0.data_out), s0.frame_done, edge_cnt});
        if (s3.data_out_valid === 1'b1) obs1.push_back('{int'(s3.data_out), s3.frame_done, edge_cnt});
    end

    // Reference: direct 2-D convolution of the frame with border/bypass rules.
    function automatic int ref_pix(input int r, input int c, input int shift);
        int sum, res, cf;
        if (r == 0 || r == ROWS-1 || c == 0 || c == COLS-1 || snap_mode == 0 || snap_mode == 3)
            return frm[r][c];
        sum = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                cf = (snap_mode == 1) ? sharp[(dr+1)*3 + dc+1] : snap_bank[(dr+1)*3 + dc+1];
                sum += cf * frm[r+dr][c+dc];
            end
        end
        res = sum >>> shift;
        if (res < 0) return 0;
        if (res > 255) return 255;
        return res;
    endfunction

    // Streams frm; starts and ends at a negedge. Writes queued in wr_q are issued
    // once wr_start pixels are in; new_mode >= 0 changes the mode input at that point.
    task automatic stream_frame(input int gap_pct, input int wr_start, input int new_mode);
        int   idx, guard, low_cnt, last_t, k;
        int   acc_t [NPIX];
        bit   mode_done;
        wr_t  w;
        out_t e;
        snap_mode = int'(mode);
        snap_bank = bank_m;
        idx = 0; guard = 0; mode_done = 0;
        while (idx < NPIX && guard < 3000) begin
            guard++;
            if (idx >= wr_start && new_mode >= 0 && !mode_done) begin
                mode = 2'(new_mode);
                mode_done = 1;
            end
            if (idx >= wr_start && wr_q.size() > 0) begin
                w = wr_q.pop_front();
                coef_wr = 1'b1; coef_addr = 4'(w.addr); coef_data = CW'(w.data);
                if (w.addr <= 8) bank_m[w.addr] = w.data;
            end else begin
                coef_wr = 1'b0;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                s0.data_in_valid = 1'b0;
            end else begin
                s0.data_in_valid = 1'b1;
                s0.data_in = 8'(frm[idx / COLS][idx % COLS]);
            end
            if (s0.data_in_valid && s0.data_in_ready) begin
                acc_t[idx] = edge_cnt;
                idx++;
            end
            @(negedge clk);
        end
        coef_wr = 1'b0;
        vectors++;
        if (idx != NPIX) begin
            miscompares++;
            $display("FAIL accept_budget: accepted %0d pixels, required %0d", idx, NPIX);
            s0.data_in_valid = 1'b0;
            return;
        end
        last_t = acc_t[NPIX-1];
        // Keep valid high through the flush: nothing may be taken while ready is low.
        s0.data_in_valid = 1'b1;
        low_cnt = 0;
        while (s0.data_in_ready !== 1'b1 && low_cnt < 20) begin
            low_cnt++;
            @(negedge clk);
        end
        s0.data_in_valid = 1'b0;
        vectors++;
        if (low_cnt != COLS + 1) begin
            miscompares++;
            $display("FAIL flush_ready_low: ready low for %0d cycles, required %0d", low_cnt, COLS + 1);
        end
        for (int j = 0; j < NPIX; j++) begin
            k = j + COLS + 1;
            e.done = (j == NPIX - 1);
            e.t    = (k < NPIX) ? acc_t[k] + 3 : last_t + (k - NPIX + 1) + 3;
            e.val  = ref_pix(j / COLS, j % COLS, 0);
            exp0.push_back(e);
            e.val  = ref_pix(j / COLS, j % COLS, 3);
            exp1.push_back(e);
        end
    endtask

    // Pops one frame of outputs from both DUTs and compares them; ends at a negedge.
    task automatic check_frame(input string name);
        int   guard;
        out_t o, e;
        guard = 0;
        while ((obs0.size() < NPIX || obs1.size() < NPIX) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        vectors++;
        if (obs0.size() < NPIX || obs1.size() < NPIX) begin
            miscompares++;
            $display("FAIL %s out_count: got %0d/%0d outputs, required %0d", name, obs0.size(), obs1.size(), NPIX);
            obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
            @(negedge clk);
            return;
        end
        for (int j = 0; j < NPIX; j++) begin
            o = obs0.pop_front(); e = exp0.pop_front(); last0[j] = o.val;
            vectors++;
            if (o.val !== e.val) begin
                miscompares++;
                $display("FAIL %s value px%0d: got %0d, required %0d", name, j, o.val, e.val);
            end
            vectors++;
            if (o.t !== e.t) begin
                miscompares++;
                $display("FAIL %s timing px%0d: at edge %0d, required %0d", name, j, o.t, e.t);
            end
            vectors++;
            if (o.done !== e.done) begin
                miscompares++;
                $display("FAIL %s frame_done px%0d: got %0d, required %0d", name, j, o.done, e.done);
            end
            o = obs1.pop_front(); e = exp1.pop_front(); last1[j] = o.val;
            vectors++;
            if (o.val !== e.val) begin
                miscompares++;
                $display("FAIL %s shift3_value px%0d: got %0d, required %0d", name, j, o.val, e.val);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        repeat (15) @(posedge clk);
        vectors++;
        if (obs0.size() != 0 || obs1.size() != 0) begin
            miscompares++;
            $display("FAIL %s extra_outputs: got %0d/%0d, required 0", name, obs0.size(), obs1.size());
            obs0.delete(); obs1.delete();
        end
        @(negedge clk);
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_wr = 1'b1; coef_addr = 4'(addr); coef_data = CW'(data);
        if (addr <= 8) bank_m[addr] = data;
        @(negedge clk);
        coef_wr = 1'b0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) frm[r][c] = int'($urandom_range(255));
    endtask

    task automatic test_reset();
        reset = 1'b0; s0.data_in_valid = 1'b0; s0.data_in = '0; bank_m = sharp;
        repeat (3) @(negedge clk);
        vectors++;
        if (s0.data_out !== 8'd0) begin miscompares++; $display("FAIL reset data_out: got %0d, required 0", s0.data_out); end
        vectors++;
        if (s0.data_out_valid !== 1'b0 || s3.data_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset data_out_valid: got %0d/%0d, required 0", s0.data_out_valid, s3.data_out_valid);
        end
        vectors++;
        if (s0.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset frame_done: got %0d, required 0", s0.frame_done); end
        vectors++;
        if (s0.data_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset data_in_ready: got %0d, required 1", s0.data_in_ready); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flat();
        mode = 2'd1;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) frm[r][c] = 100;
        stream_frame(0, 99, -1);
        check_frame("flat");
        for (int j = 0; j < NPIX; j++) begin
            vectors++;
            if (last0[j] !== 100) begin miscompares++; $display("FAIL flat const px%0d: got %0d, required 100", j, last0[j]); end
        end
        check_quiet("flat");
    endtask

    task automatic test_ramp();
        mode = 2'd1;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) frm[r][c] = r * 6 + c * 10;
        stream_frame(0, 99, -1);
        check_frame("ramp");
        check_quiet("ramp");
    endtask

    task automatic test_clamp();
        mode = 2'd1;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) frm[r][c] = 0;
        frm[1][1] = 255;
        for (int r = 2; r <= 4; r++) for (int c = 3; c <= 5; c++) frm[r][c] = 255;
        frm[3][4] = 0;
        stream_frame(0, 99, -1);
        check_frame("clamp");
        vectors++;
        if (last0[1*COLS + 1] !== 255) begin miscompares++; $display("FAIL clamp_high: got %0d, required 255", last0[1*COLS + 1]); end
        vectors++;
        if (last0[3*COLS + 4] !== 0) begin miscompares++; $display("FAIL clamp_low: got %0d, required 0", last0[3*COLS + 4]); end
        check_quiet("clamp");
    endtask

    task automatic test_prog_shadow();
        mode = 2'd1;
        fill_random();
        for (int t = 0; t < 9; t++) wr_q.push_back('{t, 1});
        wr_q.push_back('{12, -5});
        stream_frame(0, 5, 2);
        check_frame("shadow_cur");
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) frm[r][c] = 80;
        stream_frame(0, 99, -1);
        check_frame("box");
        for (int r = 1; r < ROWS-1; r++) begin
            for (int c = 1; c < COLS-1; c++) begin
                vectors++;
                if (last1[r*COLS + c] !== 90) begin
                    miscompares++; $display("FAIL box_shift3 (%0d,%0d): got %0d, required 90", r, c, last1[r*COLS + c]);
                end
            end
        end
        check_quiet("box");
    endtask

    task automatic test_gaps();
        mode = 2'd2;
        for (int t = 0; t < 9; t++) write_coef(t, int'($urandom_range(8)) - 4);
        fill_random();
        stream_frame(50, 99, -1);
        check_frame("gaps");
        stream_frame(0, 99, -1);
        check_frame("gapless");
        check_quiet("gaps");
    endtask

    task automatic test_back_to_back();
        mode = 2'd1;
        fill_random();
        stream_frame(0, 99, -1);
        mode = 2'd3;
        fill_random();
        stream_frame(0, 99, -1);
        check_frame("b2b_first");
        check_frame("b2b_second");
        check_quiet("b2b");
    endtask

    task automatic test_reset_midframe();
        int idx, guard;
        mode = 2'd1;
        fill_random();
        idx = 0; guard = 0;
        while (idx < 17 && guard < 100) begin
            guard++;
            s0.data_in_valid = 1'b1;
            s0.data_in = 8'(frm[idx / COLS][idx % COLS]);
            if (s0.data_in_ready) idx++;
            @(negedge clk);
        end
        s0.data_in_valid = 1'b0;
        reset = 1'b0;
        bank_m = sharp;
        @(negedge clk);
        reset = 1'b1;
        obs0.delete(); obs1.delete();
        vectors++;
        if (s0.data_in_ready !== 1'b1 || s0.data_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset state: ready %0d valid %0d, required 1 0", s0.data_in_ready, s0.data_out_valid);
        end
        mode = 2'd2;
        fill_random();
        stream_frame(0, 99, -1);
        check_frame("after_reset");
        check_quiet("after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_flat();
        test_ramp();
        test_clamp();
        test_prog_shadow();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
